// File: rtl/uart_pkg.sv
// Shared constants, state encodings and parity helper for the FIFO-buffered UART.
package uart_pkg;

    localparam int PAR_NONE   = 0;
    localparam int PAR_ODD    = 1;
    localparam int PAR_EVEN   = 2;
    localparam int OVERSAMPLE = 16;

    typedef enum logic [2:0] {
        TX_IDLE   = 3'd0,
        TX_START  = 3'd1,
        TX_DATA   = 3'd2,
        TX_PARITY = 3'd3,
        TX_STOP   = 3'd4
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE   = 3'd0,
        RX_START  = 3'd1,
        RX_DATA   = 3'd2,
        RX_PARITY = 3'd3,
        RX_STOP   = 3'd4
    } rx_state_t;

    // Unused upper bits of data must be zero; odd = 1 inverts the even result.
    function automatic logic parity_bit(input logic [8:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous show-ahead FIFO used for both the TX and RX queues.
module uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign full      = (count_r == CNT_W'(DEPTH));
    assign empty     = (count_r == {CNT_W{1'b0}});
    assign push_ok_s = push && !full;
    assign pop_ok_s  = pop && !empty;
    assign pop_data  = empty ? {WIDTH{1'b0}} : mem_r[rd_ptr_r];

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            wr_ptr_r <= push_ok_s ? wr_ptr_r + PTR_W'(1) : wr_ptr_r;
            rd_ptr_r <= pop_ok_s ? rd_ptr_r + PTR_W'(1) : rd_ptr_r;
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Storage array, written only on an accepted push.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

endmodule

// File: rtl/uart_fifo_top.sv
// UART with 16x oversampling, TX/RX FIFOs, optional parity, loopback and sticky error flags.
module uart_fifo_top
    import uart_pkg::*;
#(
    parameter int CLOCK_FREQ = 50000000,
    parameter int BAUD_RATE  = 9600,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 loopback_en,
    input  logic                 rx_pin,
    output logic                 tx_pin,
    input  logic                 tx_wr_en,
    input  logic [DATA_BITS-1:0] tx_wr_data,
    output logic                 tx_full,
    output logic                 tx_busy,
    input  logic                 rx_rd_en,
    output logic [DATA_BITS-1:0] rx_rd_data,
    output logic                 rx_empty,
    output logic                 rx_parity_err,
    output logic                 rx_frame_err,
    output logic                 rx_overrun,
    input  logic                 err_clr
);

    localparam int         DIV        = CLOCK_FREQ / (BAUD_RATE * OVERSAMPLE);
    localparam int         DIV_W      = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [3:0] LAST_TICK  = 4'(OVERSAMPLE - 1);
    localparam logic [3:0] MID_TICK   = 4'(OVERSAMPLE / 2 - 1);
    localparam logic [3:0] LAST_BIT   = 4'(DATA_BITS - 1);
    localparam logic       ODD_MODE   = (PARITY == PAR_ODD);
    localparam logic       HAS_PARITY = (PARITY != PAR_NONE);

    logic [DIV_W-1:0]     div_cnt_r;
    logic                 tick_s;
    tx_state_t            tx_state_r, tx_state_next;
    logic [3:0]           tx_tick_r, tx_tick_next, tx_bit_r, tx_bit_next;
    logic [DATA_BITS-1:0] tx_shift_r, tx_shift_next, tx_fifo_data_s;
    logic                 tx_par_r, tx_par_next, tx_pin_r, tx_line_s, tx_bit_end_s;
    logic                 tx_pop_s, tx_fifo_empty_s;
    rx_state_t            rx_state_r, rx_state_next;
    logic [3:0]           rx_tick_r, rx_tick_next, rx_bit_r, rx_bit_next;
    logic [DATA_BITS-1:0] rx_shift_r, rx_shift_next;
    logic                 rx_par_r, rx_par_next, rx_sample_s, rx_fifo_full_s;
    logic                 sync1_r, sync2_r, rx_push_s;
    logic                 frame_set_s, parity_set_s, overrun_set_s;
    logic                 parity_err_r, frame_err_r, overrun_r;

    assign tick_s        = (div_cnt_r == DIV_W'(DIV - 1));
    assign tx_bit_end_s  = tick_s && (tx_tick_r == LAST_TICK);
    assign rx_sample_s   = tick_s && (rx_tick_r == LAST_TICK);
    assign tx_pin        = tx_pin_r;
    assign tx_busy       = (tx_state_r != TX_IDLE) || !tx_fifo_empty_s;
    assign rx_parity_err = parity_err_r;
    assign rx_frame_err  = frame_err_r;
    assign rx_overrun    = overrun_r;

    uart_sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk(clk), .rst_n(reset), .push(tx_wr_en), .push_data(tx_wr_data),
        .pop(tx_pop_s), .pop_data(tx_fifo_data_s), .full(tx_full), .empty(tx_fifo_empty_s)
    );

    uart_sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk(clk), .rst_n(reset), .push(rx_push_s), .push_data(rx_shift_r),
        .pop(rx_rd_en), .pop_data(rx_rd_data), .full(rx_fifo_full_s), .empty(rx_empty)
    );

    // Free-running oversample tick divider.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_cnt_r <= {DIV_W{1'b0}};
        end else begin
            div_cnt_r <= tick_s ? {DIV_W{1'b0}} : div_cnt_r + DIV_W'(1);
        end
    end

    // TX state register; the line itself is re-registered so the pin is glitch-free.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_state_r <= TX_IDLE;
            tx_tick_r  <= 4'd0;
            tx_bit_r   <= 4'd0;
            tx_shift_r <= {DATA_BITS{1'b0}};
            tx_par_r   <= 1'b0;
            tx_pin_r   <= 1'b1;
        end else begin
            tx_state_r <= tx_state_next;
            tx_tick_r  <= tx_tick_next;
            tx_bit_r   <= tx_bit_next;
            tx_shift_r <= tx_shift_next;
            tx_par_r   <= tx_par_next;
            tx_pin_r   <= tx_line_s;
        end
    end

    // TX next state: a word is popped either from IDLE or straight out of STOP.
    always_comb begin
        tx_state_next = tx_state_r;
        tx_tick_next  = tick_s ? tx_tick_r + 4'd1 : tx_tick_r;
        tx_bit_next   = tx_bit_r;
        tx_shift_next = tx_shift_r;
        tx_par_next   = tx_par_r;
        tx_pop_s      = 1'b0;
        case (tx_state_r)
            TX_IDLE: begin
                tx_pop_s      = !tx_fifo_empty_s;
                tx_state_next = tx_fifo_empty_s ? TX_IDLE : TX_START;
            end
            TX_START: begin
                if (tx_bit_end_s) begin
                    tx_state_next = TX_DATA;
                    tx_bit_next   = 4'd0;
                end else begin
                    tx_state_next = TX_START;
                end
            end
            TX_DATA: begin
                if (tx_bit_end_s) begin
                    tx_shift_next = tx_shift_r >> 1;
                    tx_bit_next   = tx_bit_r + 4'd1;
                    if (tx_bit_r == LAST_BIT) begin
                        tx_state_next = HAS_PARITY ? TX_PARITY : TX_STOP;
                    end else begin
                        tx_state_next = TX_DATA;
                    end
                end else begin
                    tx_state_next = TX_DATA;
                end
            end
            TX_PARITY: tx_state_next = tx_bit_end_s ? TX_STOP : TX_PARITY;
            TX_STOP: begin
                if (tx_bit_end_s) begin
                    tx_pop_s      = !tx_fifo_empty_s;
                    tx_state_next = tx_fifo_empty_s ? TX_IDLE : TX_START;
                end else begin
                    tx_state_next = TX_STOP;
                end
            end
            default: tx_state_next = TX_IDLE;
        endcase
        if (tx_pop_s) begin
            tx_shift_next = tx_fifo_data_s;
            tx_par_next   = parity_bit(9'(tx_fifo_data_s), ODD_MODE);
            tx_tick_next  = 4'd0;
        end else begin
            tx_par_next   = tx_par_r;
        end
    end

    // TX line level per state.
    always_comb begin
        tx_line_s = 1'b1;
        case (tx_state_r)
            TX_START:  tx_line_s = 1'b0;
            TX_DATA:   tx_line_s = tx_shift_r[0];
            TX_PARITY: tx_line_s = tx_par_r;
            default:   tx_line_s = 1'b1;
        endcase
    end

    // Loopback mux ahead of the two-stage synchroniser.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_r <= 1'b1;
            sync2_r <= 1'b1;
        end else begin
            sync1_r <= loopback_en ? tx_pin_r : rx_pin;
            sync2_r <= sync1_r;
        end
    end

    // RX state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_state_r <= RX_IDLE;
            rx_tick_r  <= 4'd0;
            rx_bit_r   <= 4'd0;
            rx_shift_r <= {DATA_BITS{1'b0}};
            rx_par_r   <= 1'b0;
        end else begin
            rx_state_r <= rx_state_next;
            rx_tick_r  <= rx_tick_next;
            rx_bit_r   <= rx_bit_next;
            rx_shift_r <= rx_shift_next;
            rx_par_r   <= rx_par_next;
        end
    end

    // RX next state: mid-start re-check, then one sample every 16 ticks.
    always_comb begin
        rx_state_next = rx_state_r;
        rx_tick_next  = tick_s ? rx_tick_r + 4'd1 : rx_tick_r;
        rx_bit_next   = rx_bit_r;
        rx_shift_next = rx_shift_r;
        rx_par_next   = rx_par_r;
        case (rx_state_r)
            RX_IDLE: begin
                rx_tick_next  = 4'd0;
                rx_state_next = (tick_s && !sync2_r) ? RX_START : RX_IDLE;
            end
            RX_START: begin
                if (tick_s && (rx_tick_r == MID_TICK)) begin
                    rx_state_next = sync2_r ? RX_IDLE : RX_DATA;
                    rx_tick_next  = 4'd0;
                    rx_bit_next   = 4'd0;
                end else begin
                    rx_state_next = RX_START;
                end
            end
            RX_DATA: begin
                if (rx_sample_s) begin
                    rx_shift_next = {sync2_r, rx_shift_r[DATA_BITS-1:1]};
                    rx_bit_next   = rx_bit_r + 4'd1;
                    if (rx_bit_r == LAST_BIT) begin
                        rx_state_next = HAS_PARITY ? RX_PARITY : RX_STOP;
                    end else begin
                        rx_state_next = RX_DATA;
                    end
                end else begin
                    rx_state_next = RX_DATA;
                end
            end
            RX_PARITY: begin
                rx_par_next   = rx_sample_s ? sync2_r : rx_par_r;
                rx_state_next = rx_sample_s ? RX_STOP : RX_PARITY;
            end
            RX_STOP: rx_state_next = rx_sample_s ? RX_IDLE : RX_STOP;
            default: rx_state_next = RX_IDLE;
        endcase
    end

    // Stop-sample verdict, checked in priority order: framing, parity, overrun.
    always_comb begin
        rx_push_s     = 1'b0;
        frame_set_s   = 1'b0;
        parity_set_s  = 1'b0;
        overrun_set_s = 1'b0;
        if ((rx_state_r == RX_STOP) && rx_sample_s) begin
            if (!sync2_r) begin
                frame_set_s = 1'b1;
            end else if (HAS_PARITY && (rx_par_r != parity_bit(9'(rx_shift_r), ODD_MODE))) begin
                parity_set_s = 1'b1;
            end else if (rx_fifo_full_s) begin
                overrun_set_s = 1'b1;
            end else begin
                rx_push_s = 1'b1;
            end
        end else begin
            rx_push_s = 1'b0;
        end
    end

    // Sticky error flags; a set in the clearing cycle takes priority.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            parity_err_r <= 1'b0;
            frame_err_r  <= 1'b0;
            overrun_r    <= 1'b0;
        end else begin
            parity_err_r <= parity_set_s | (parity_err_r & ~err_clr);
            frame_err_r  <= frame_set_s | (frame_err_r & ~err_clr);
            overrun_r    <= overrun_set_s | (overrun_r & ~err_clr);
        end
    end

endmodule

// File: tb/tb_uart_fifo_top.sv
// Self-checking bench: even-parity DUT for loopback/FIFO/error tests, odd-parity DUT for parity errors.
module tb_uart_fifo_top;

    localparam int CLK_FREQ = 320000;
    localparam int BAUD     = 10000;
    localparam int DEPTH    = 16;
    localparam int BIT_CLKS = 32;   // 16 ticks of a 2-clock divisor

    logic       clk = 1'b0;
    logic       reset;
    logic       loopback_a, rx_pin_a, tx_wr_en_a, rx_rd_en_a, err_clr_a;
    logic [7:0] tx_wr_data_a;
    logic       tx_pin_a, tx_full_a, tx_busy_a, rx_empty_a, perr_a, ferr_a, ovr_a;
    logic [7:0] rx_rd_data_a;
    logic       rx_pin_b, rx_rd_en_b, err_clr_b;
    logic       tx_pin_b, tx_full_b, tx_busy_b, rx_empty_b, perr_b, ferr_b, ovr_b;
    logic [7:0] rx_rd_data_b;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] data;
        logic       par_flip;
        logic       stop_val;
        logic       exp_push;
        logic       exp_perr;
        logic       exp_ferr;
    } vec_t;
    vec_t       vecs [12];
    logic [7:0] exp_q [$];

    always #5 clk = ~clk;

    uart_fifo_top #(.CLOCK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD), .DATA_BITS(8), .PARITY(2), .FIFO_DEPTH(DEPTH)) u_dut_a (
        .clk(clk), .reset(reset), .loopback_en(loopback_a), .rx_pin(rx_pin_a), .tx_pin(tx_pin_a),
        .tx_wr_en(tx_wr_en_a), .tx_wr_data(tx_wr_data_a), .tx_full(tx_full_a), .tx_busy(tx_busy_a),
        .rx_rd_en(rx_rd_en_a), .rx_rd_data(rx_rd_data_a), .rx_empty(rx_empty_a),
        .rx_parity_err(perr_a), .rx_frame_err(ferr_a), .rx_overrun(ovr_a), .err_clr(err_clr_a)
    );

    uart_fifo_top #(.CLOCK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD), .DATA_BITS(8), .PARITY(1), .FIFO_DEPTH(DEPTH)) u_dut_b (
        .clk(clk), .reset(reset), .loopback_en(1'b0), .rx_pin(rx_pin_b), .tx_pin(tx_pin_b),
        .tx_wr_en(1'b0), .tx_wr_data(8'h00), .tx_full(tx_full_b), .tx_busy(tx_busy_b),
        .rx_rd_en(rx_rd_en_b), .rx_rd_data(rx_rd_data_b), .rx_empty(rx_empty_b),
        .rx_parity_err(perr_b), .rx_frame_err(ferr_b), .rx_overrun(ovr_b), .err_clr(err_clr_b)
    );

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference verdict for a received frame: {push, parity_err, frame_err}.
    function automatic logic [2:0] rx_expect(input logic par_flip, input logic stop_val);
        if (!stop_val) return 3'b001;
        if (par_flip) return 3'b010;
        return 3'b100;
    endfunction

    // Reference frame: start, data LSB first, parity, stop.
    function automatic logic [10:0] make_frame(input logic [7:0] d, input logic odd, input logic flip, input logic stop_val);
        return {stop_val, (^d) ^ odd ^ flip, d, 1'b0};
    endfunction

    // A low stop bit is shortened so the line is high again before the receiver can re-arm on it.
    task automatic send_rx(input bit to_b, input logic [7:0] d, input logic odd, input logic flip, input logic stop_val);
        logic [10:0] f;
        f = make_frame(d, odd, flip, stop_val);
        for (int i = 0; i < 11; i++) begin
            if (to_b) rx_pin_b = f[i]; else rx_pin_a = f[i];
            step((i == 10 && !stop_val) ? 24 : BIT_CLKS);
        end
        rx_pin_a = 1'b1;
        rx_pin_b = 1'b1;
        step(2 * BIT_CLKS);
    endtask

    task automatic push_a(input logic [7:0] d);
        tx_wr_en_a = 1'b1; tx_wr_data_a = d;
        step(1);
        tx_wr_en_a = 1'b0;
    endtask

    task automatic pop_a();
        rx_rd_en_a = 1'b1; step(1); rx_rd_en_a = 1'b0;
    endtask

    task automatic clear_a();
        err_clr_a = 1'b1; step(1); err_clr_a = 1'b0;
    endtask

    task automatic wait_rx_a(input string name, input int limit);
        int n = 0;
        while (rx_empty_a && n < limit) begin step(1); n++; end
        check(name, 32'(n < limit), 32'd1);
    endtask

    task automatic wait_idle_a(input string name, input int limit);
        int n = 0;
        while (tx_busy_a && n < limit) begin step(1); n++; end
        check(name, 32'(n < limit), 32'd1);
    endtask

    task automatic wait_fall_a(input string name);
        int n = 0;
        while (tx_pin_a !== 1'b0 && n < 100) begin step(1); n++; end
        check(name, 32'(n < 100), 32'd1);
    endtask

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [10:0] fr;
        logic [2:0]  ex;
        logic [7:0]  d;
        int          nw;

        reset = 1'b0; loopback_a = 1'b0; rx_pin_a = 1'b1; rx_pin_b = 1'b1;
        tx_wr_en_a = 1'b0; tx_wr_data_a = 8'h00; rx_rd_en_a = 1'b0; err_clr_a = 1'b0;
        rx_rd_en_b = 1'b0; err_clr_b = 1'b0;
        step(3);
        check("rst_tx_pin", tx_pin_a, 1); check("rst_tx_full", tx_full_a, 0);
        check("rst_tx_busy", tx_busy_a, 0); check("rst_rx_empty", rx_empty_a, 1);
        check("rst_rx_data", rx_rd_data_a, 0);
        check("rst_flags", {perr_a, ferr_a, ovr_a}, 0);
        reset = 1'b1;
        step(4);

        // Loopback 0xA5, even parity: check every bit on the wire and the received word.
        loopback_a = 1'b1;
        push_a(8'hA5);
        check("busy_after_push", tx_busy_a, 1);
        wait_fall_a("a5_start_seen");
        fr = make_frame(8'hA5, 1'b0, 1'b0, 1'b1);
        step(BIT_CLKS / 2);
        for (int i = 0; i < 11; i++) begin
            check($sformatf("a5_tx_bit%0d", i), tx_pin_a, fr[i]);
            step(BIT_CLKS);
        end
        wait_rx_a("a5_rx_timeout", 200);
        check("a5_rx_data", rx_rd_data_a, 8'hA5);
        check("a5_flags", {perr_a, ferr_a, ovr_a}, 0);
        pop_a();
        check("a5_empty_after_pop", rx_empty_a, 1);
        check("a5_idle", tx_busy_a, 0);

        // Random loopback bursts against a queue model.
        for (int r = 0; r < 3; r++) begin
            nw = $urandom_range(1, 4);
            for (int k = 0; k < nw; k++) begin
                d = 8'($urandom);
                exp_q.push_back(d);
                push_a(d);
            end
            wait_idle_a("burst_idle_timeout", 2000);
            step(BIT_CLKS);
            while (exp_q.size() > 0) begin
                d = exp_q.pop_front();
                check("burst_not_empty", rx_empty_a, 0);
                check("burst_data", rx_rd_data_a, d);
                pop_a();
            end
            check("burst_drained", rx_empty_a, 1);
            check("burst_flags", {perr_a, ferr_a, ovr_a}, 0);
        end

        // Overflow: one word sits in the transmitter, DEPTH more fill the TX FIFO.
        for (int k = 0; k <= DEPTH; k++) begin
            tx_wr_en_a = 1'b1; tx_wr_data_a = 8'(k);
            step(1);
        end
        check("ovf_tx_full", tx_full_a, 1);
        tx_wr_data_a = 8'hEE;
        step(1);
        tx_wr_en_a = 1'b0;
        check("ovf_tx_full_hold", tx_full_a, 1);
        wait_idle_a("ovf_idle_timeout", 8000);
        step(2 * BIT_CLKS);
        check("ovf_overrun", ovr_a, 1);
        for (int k = 0; k < DEPTH; k++) begin
            check($sformatf("ovf_word%0d", k), rx_rd_data_a, 32'(k));
            pop_a();
        end
        check("ovf_drained", rx_empty_a, 1);
        clear_a();
        check("ovf_clr", ovr_a, 0);

        // Table of external frames on rx_pin: fixed corner cases then random ones.
        loopback_a = 1'b0;
        step(4);
        vecs[0] = '{8'h3C, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{8'h81, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[2] = '{8'h55, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[3] = '{8'hFF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        for (int i = 4; i < 12; i++) begin
            vecs[i].data     = 8'($urandom);
            vecs[i].par_flip = 1'($urandom_range(0, 1));
            vecs[i].stop_val = ($urandom_range(0, 3) != 0);
            ex = rx_expect(vecs[i].par_flip, vecs[i].stop_val);
            {vecs[i].exp_push, vecs[i].exp_perr, vecs[i].exp_ferr} = ex;
        end
        for (int i = 0; i < 12; i++) begin
            send_rx(1'b0, vecs[i].data, 1'b0, vecs[i].par_flip, vecs[i].stop_val);
            check($sformatf("vec%0d_empty", i), rx_empty_a, !vecs[i].exp_push);
            if (vecs[i].exp_push) check($sformatf("vec%0d_data", i), rx_rd_data_a, vecs[i].data);
            check($sformatf("vec%0d_perr", i), perr_a, vecs[i].exp_perr);
            check($sformatf("vec%0d_ferr", i), ferr_a, vecs[i].exp_ferr);
            check($sformatf("vec%0d_ovr", i), ovr_a, 0);
            if (!rx_empty_a) pop_a();
            clear_a();
            check($sformatf("vec%0d_clr", i), {perr_a, ferr_a}, 0);
        end

        // Three-tick low glitch on an idle line.
        rx_pin_a = 1'b0; step(6); rx_pin_a = 1'b1;
        step(12 * BIT_CLKS);
        check("glitch_no_word", rx_empty_a, 1);
        check("glitch_no_flag", {perr_a, ferr_a, ovr_a}, 0);

        // Odd parity DUT: wrong parity bit on 0x3C, clear, then a good frame.
        send_rx(1'b1, 8'h3C, 1'b1, 1'b1, 1'b1);
        check("odd_perr", perr_b, 1);
        check("odd_empty", rx_empty_b, 1);
        err_clr_b = 1'b1; step(1); err_clr_b = 1'b0;
        check("odd_clr", perr_b, 0);
        send_rx(1'b1, 8'h3C, 1'b1, 1'b0, 1'b1);
        check("odd_good_empty", rx_empty_b, 0);
        check("odd_good_data", rx_rd_data_b, 8'h3C);
        check("odd_good_perr", perr_b, 0);

        // Reset in the middle of DATA with a second word still queued.
        loopback_a = 1'b1;
        step(2);
        push_a(8'h33);
        push_a(8'h44);
        wait_fall_a("rst_mid_start_seen");
        step(3 * BIT_CLKS);
        check("rst_mid_pre_busy", tx_busy_a, 1);
        reset = 1'b0;
        #1;
        check("rst_mid_tx_pin", tx_pin_a, 1);
        check("rst_mid_busy", tx_busy_a, 0);
        check("rst_mid_rx_empty", rx_empty_a, 1);
        step(3);
        reset = 1'b1;
        step(12 * BIT_CLKS);
        check("rst_mid_lost", rx_empty_a, 1);
        check("rst_mid_idle", tx_busy_a, 0);
        push_a(8'h5A);
        wait_rx_a("resume_rx_timeout", 600);
        check("resume_data", rx_rd_data_a, 8'h5A);
        check("resume_flags", {perr_a, ferr_a, ovr_a}, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
